// File: rtl/route_cfg_if.sv
// rtl/route_cfg_if.sv - word handshake and serial shift bundle for route_cfg_serializer
interface route_cfg_if #(
  parameter int WIDTH  = 64,
  parameter int WCNT_W = 16
);
  logic [WIDTH-1:0]  word_in;
  logic              word_valid;
  logic              word_ready;
  logic              stall;
  logic              shift;
  logic              sr_in;
  logic              busy;
  logic              word_done;
  logic [WCNT_W-1:0] word_count;

  // Config controller side: offers words and stalls, observes serializer status.
  modport master (
    output word_in, word_valid, stall,
    input  word_ready, shift, sr_in, busy, word_done, word_count
  );

  // Serializer side.
  modport slave (
    input  word_in, word_valid, stall,
    output word_ready, shift, sr_in, busy, word_done, word_count
  );
endinterface

// File: rtl/route_cfg_serializer.sv
// rtl/route_cfg_serializer.sv - serializes parallel routing words MSB-first into shift_1x64
module route_cfg_serializer #(
  parameter int WIDTH  = 64,
  parameter int CNT_W  = 7,
  parameter int WCNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  route_cfg_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WCNT_W-1:0] word_count;

  // Sequencing: latch a word in IDLE, shift one bit per unstalled edge, count it on leaving DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.word_valid) begin
            sreg    <= bus.word_in;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus.stall) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              state <= DONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          word_count <= word_count + WCNT_W'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is masked by rst so it stays low while reset is held and rises as soon as it drops.
  assign bus.word_ready = (state == IDLE) && !rst;
  // Stall gates the shift enable combinationally so the downstream register freezes the same cycle.
  assign bus.shift      = (state == SHIFT) && !bus.stall;
  // sreg is zero after reset and after a full word, so sr_in idles low outside SHIFT.
  assign bus.sr_in      = sreg[WIDTH-1];
  assign bus.busy       = (state == SHIFT) || (state == DONE);
  assign bus.word_done  = (state == DONE);
  assign bus.word_count = word_count;

endmodule
